send_player_input: RTL
======================

Name: send_player_input

Overview:
- Player-side transmitter for the player-action handshake. The game controller raises request_input; this block collects the action and bet from the player's switches and submit button, legalises them against the stack and the amount to call, then drives players_input, players_money and valid_input.
- It holds the data until accepted_input is seen, then releases valid_input.
- One instance per human seat, sitting between the board I/O and the game controller.

Parameters:
- TIMEOUT_CYCLES, 24'd10_000_000, cycles in WAIT_CHOICE before an automatic action (used only with the optional feature).
- CNT_W, 24, width of the timeout counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- request_input  in  1  controller asks this player for an action
- accepted_input  in  1  controller has stored the data
- sw_action  in  3  selected action: 0 FOLD, 1 CHECK, 2 CALL, 3 RAISE, 4 ALL_IN; 5-7 illegal
- sw_money  in  8  raise amount from switches
- submit  in  1  debounced button, asynchronous to clk
- player_stack  in  8  player's remaining money
- call_amount  in  8  amount needed to call
- players_input  out  3  registered action code
- players_money  out  8  registered bet
- valid_input  out  1  data valid to controller
- waiting_for_player  out  1  high in WAIT_CHOICE; drives the VGA prompt
- input_error  out  1  one-cycle pulse when a submission is rejected

Behaviour:
- Reset values: players_input=0, players_money=0, valid_input=0, waiting_for_player=0, input_error=0, state=IDLE, sync flops=0. Reset mid-handshake returns to IDLE immediately.
- Submit input:
  - submit passes through a 2-flop synchroniser, then a rising-edge detector.
  - Only an edge detected while in WAIT_CHOICE counts. A button already held when WAIT_CHOICE is entered does not count.
- State IDLE:
  - request_input=1 -> WAIT_CHOICE.
- State WAIT_CHOICE (waiting_for_player=1):
  - request_input=0 -> IDLE. The request was withdrawn; nothing is sent.
  - On a submit edge, legalise sw_action using that cycle's inputs:
    - FOLD: money=0.
    - CHECK: legal only if call_amount==0; money=0.
    - CALL: money = min(call_amount, player_stack).
    - RAISE: legal only if sw_money > call_amount; money = min(sw_money, player_stack).
    - ALL_IN: money=player_stack.
    - Codes 5-7: illegal.
  - Legal submission: latch the action code and money, set valid_input=1 on the next cycle, go to SEND_VALID.
  - Illegal submission: pulse input_error for 1 cycle and stay in WAIT_CHOICE.
- State SEND_VALID:
  - valid_input=1; players_input and players_money are held stable.
  - request_input is ignored here (the controller drops it while accepting).
  - accepted_input=1 -> clear valid_input on the next cycle, go to WAIT_ACCEPT_LOW.
- State WAIT_ACCEPT_LOW:
  - valid_input=0.
  - accepted_input=0 -> IDLE. Data outputs keep their last values.
  - A request_input that is still high is not re-served until accepted_input falls and IDLE is re-entered.
- Latency:
  - Submit pin edge -> valid_input high: 4 clk (2 sync, 1 detect, 1 register).
  - accepted_input high -> valid_input low: 1 clk.
- Arithmetic: all compares are unsigned 8-bit. min() selects the smaller operand with no wrap.
- Simultaneous events in WAIT_CHOICE: request_input falling on the same cycle as a submit edge -> the abort wins and goes to IDLE; input_error is not pulsed.

Optional Feature:
- Macro: SEND_PLAYER_INPUT_TIMEOUT_EN.
- Defined:
  - A CNT_W counter clears on WAIT_CHOICE entry and increments each cycle in WAIT_CHOICE.
  - When it reaches TIMEOUT_CYCLES-1 with no legal submit that cycle, send an automatic action: CHECK (money 0) if call_amount==0, else FOLD (money 0), through the same SEND_VALID path.
  - A legal submit on the expiry cycle takes priority.
  - An illegal submit (input_error) does not reset the counter.
- Undefined: no counter; WAIT_CHOICE waits indefinitely.

Test Plan:
- Basic CALL: stack=100, call=20, action=2, submit pulse after request -> players_input=2, players_money=20, valid_input 4 clk after the edge; accepted_input high -> valid low 1 clk later; accepted low -> IDLE.
- RAISE clamp: stack=50, call=10, sw_money=80, action=3 -> money=50. Then sw_money=10, action=3 -> input_error pulse, no valid.
- Illegal CHECK: call=5, action=1 -> input_error, stay in WAIT_CHOICE. Then action=0 submit -> valid with players_input=0, money=0.
- Request withdrawn: request high 5 clk, then low with no submit -> IDLE, valid never asserts. Submit held high across request entry -> no send until release and re-press.
- Full round-trip with the controller's receiver: data stable while valid_input is high; accepted_players_input/accepted_players_money match; no second accept; reset asserted during SEND_VALID -> valid_input=0 immediately.
- With SEND_PLAYER_INPUT_TIMEOUT_EN and TIMEOUT_CYCLES=16, call=0, no submit -> CHECK/0 sent at cycle 16 of WAIT_CHOICE. Same with call=30 -> FOLD/0 sent.

Source files
------------

// File: rtl/send_player_input.sv
// +-------------------------------------------------------------------------+
// | send_player_input: player-side action transmitter for the player-action |
// | handshake. Optional macro: SEND_PLAYER_INPUT_TIMEOUT_EN (auto action).   |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module send_player_input #(
  parameter int unsigned      CNT_W          = 24,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       request_input,
  input  logic       accepted_input,
  input  logic [2:0] sw_action,
  input  logic [7:0] sw_money,
  input  logic       submit,
  input  logic [7:0] player_stack,
  input  logic [7:0] call_amount,
  output logic [2:0] players_input,
  output logic [7:0] players_money,
  output logic       valid_input,
  output logic       waiting_for_player,
  output logic       input_error
);

  typedef enum logic [1:0] {
    S_IDLE            = 2'd0,
    S_WAIT_CHOICE     = 2'd1,
    S_SEND_VALID      = 2'd2,
    S_WAIT_ACCEPT_LOW = 2'd3
  } state_t;

  localparam logic [2:0] ACT_FOLD   = 3'd0;
  localparam logic [2:0] ACT_CHECK  = 3'd1;
  localparam logic [2:0] ACT_CALL   = 3'd2;
  localparam logic [2:0] ACT_RAISE  = 3'd3;
  localparam logic [2:0] ACT_ALL_IN = 3'd4;

`ifdef SEND_PLAYER_INPUT_TIMEOUT_EN
  localparam logic TIMEOUT_EN = 1'b1;
`else
  localparam logic TIMEOUT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CYCLES - CNT_ONE;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             submit_prev_q, submit_prev_d;
  logic             edge_q, edge_d;
  logic [2:0]       players_input_q, players_input_d;
  logic [7:0]       players_money_q, players_money_d;
  logic             valid_q, valid_d;
  logic             input_error_q, input_error_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             legal;
  logic [7:0]       legal_money;
  logic             timeout_hit;

  // Legalise the switch selection against this cycle's stack and call amount.
  always_comb begin
    legal       = 1'b0;
    legal_money = 8'd0;
    case (sw_action)
      ACT_FOLD:   legal = 1'b1;
      ACT_CHECK:  legal = (call_amount == 8'd0);
      ACT_CALL: begin
        legal       = 1'b1;
        legal_money = (call_amount < player_stack) ? call_amount : player_stack;
      end
      ACT_RAISE: begin
        legal       = (sw_money > call_amount);
        legal_money = (sw_money < player_stack) ? sw_money : player_stack;
      end
      ACT_ALL_IN: begin
        legal       = 1'b1;
        legal_money = player_stack;
      end
      default: legal = 1'b0;
    endcase
  end

  // In the default build the counter is held at zero and never matters.
  assign timeout_hit = TIMEOUT_EN && (cnt_q == TIMEOUT_LAST);

  always_comb begin
    sync1_d         = submit;
    sync2_d         = sync1_q;
    submit_prev_d   = sync2_q;
    edge_d          = sync2_q & ~submit_prev_q & (state_q == S_WAIT_CHOICE);
    state_d         = state_q;
    players_input_d = players_input_q;
    players_money_d = players_money_q;
    input_error_d   = 1'b0;
    cnt_d           = '0;

    case (state_q)
      S_IDLE: begin
        if (request_input) state_d = S_WAIT_CHOICE;
      end
      S_WAIT_CHOICE: begin
        if (TIMEOUT_EN) cnt_d = cnt_q + CNT_ONE;
        // A withdrawn request beats any simultaneous submission.
        if (!request_input) begin
          state_d = S_IDLE;
        end else if (edge_q && legal) begin
          players_input_d = sw_action;
          players_money_d = legal_money;
          state_d         = S_SEND_VALID;
        end else begin
          if (edge_q) input_error_d = 1'b1;
          if (timeout_hit) begin
            players_input_d = (call_amount == 8'd0) ? ACT_CHECK : ACT_FOLD;
            players_money_d = 8'd0;
            state_d         = S_SEND_VALID;
          end
        end
      end
      S_SEND_VALID: begin
        if (accepted_input) state_d = S_WAIT_ACCEPT_LOW;
      end
      S_WAIT_ACCEPT_LOW: begin
        if (!accepted_input) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    valid_d = (state_d == S_SEND_VALID);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      sync1_q         <= 1'b0;
      sync2_q         <= 1'b0;
      submit_prev_q   <= 1'b0;
      edge_q          <= 1'b0;
      players_input_q <= 3'd0;
      players_money_q <= 8'd0;
      valid_q         <= 1'b0;
      input_error_q   <= 1'b0;
      cnt_q           <= '0;
    end else begin
      state_q         <= state_d;
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      submit_prev_q   <= submit_prev_d;
      edge_q          <= edge_d;
      players_input_q <= players_input_d;
      players_money_q <= players_money_d;
      valid_q         <= valid_d;
      input_error_q   <= input_error_d;
      cnt_q           <= cnt_d;
    end
  end

  assign players_input      = players_input_q;
  assign players_money      = players_money_q;
  assign valid_input        = valid_q;
  assign input_error        = input_error_q;
  assign waiting_for_player = (state_q == S_WAIT_CHOICE);

endmodule

`default_nettype wire
